id_ctrl_stage: RTL and testbench
================================

ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-002 SHALL have: if_valid input 1 (instruction offered); if_instr input 16 (instruction, [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/funCode); id_ready output 1 (instruction accepted this cycle when if_valid also 1).
REQ-003 SHALL have: ex_stall input 1 (EX cannot advance, hold register); ex_flush input 1 (branch taken, discard wrong path).
REQ-004 SHALL have ID/EX register outputs: ex_valid 1; ex_aluOp 3 (to ALU control); ex_funCode 4; ex_regWrite 1; ex_memRead 1; ex_memWrite 1; ex_branch 1; ex_aluSrc 1; ex_rd 4; ex_rs 4; ex_rt 4.
REQ-005 SHALL have status outputs: halted 1 (HALT retired from decode); illegal 1 (sticky, undefined opcode seen).

Function
REQ-006 SHALL decode opcodes: 0000 R-type -> aluOp 000, funCode=instr[3:0], regWrite; 1000 LW -> aluOp 100, memRead, regWrite, aluSrc; 1011 SW -> aluOp 100, memWrite, aluSrc; 0100 BEQ -> aluOp 010, branch; 0101 ALU-immediate -> aluOp 011, regWrite, aluSrc; 1111 HALT; all others illegal.
REQ-007 SHALL drive ex_funCode=0000 for every non-R-type instruction.
REQ-008 SHALL define load-use hazard: if_valid & ex_valid & ex_memRead & ex_rd!=0 & (ex_rd==instr[7:4] | ex_rd==instr[3:0]).
REQ-009 SHALL drive id_ready = state RUN & !ex_stall & !ex_flush & !hazard (combinational).
REQ-010 SHALL apply per-edge priority: ex_flush > ex_stall > hazard > accept > idle.
REQ-011 ex_flush: next ex_valid=0, all ex_* control bits 0, instruction not accepted.
REQ-012 ex_stall (no flush): ID/EX register holds every field unchanged.
REQ-013 hazard (no flush/stall): load bubble (ex_valid=0, controls 0); instruction held upstream, accepted the following cycle; latency exactly one bubble.
REQ-014 accept of legal non-HALT: ID/EX loads decoded fields, ex_valid=1, latency one cycle.
REQ-015 if_valid=0 with register free: load bubble.
REQ-016 accept of illegal opcode: instruction consumed, bubble loaded, illegal set to 1 and held until reset.
REQ-017 FSM states RUN, HALTED; RUN->HALTED on accept of HALT (HALT loads a bubble); HALTED holds until reset; in HALTED id_ready=0, ID/EX loads bubbles unless ex_stall, halted=1.
REQ-018 HALT with coincident ex_flush SHALL NOT be accepted; state stays RUN.

Reset
REQ-019 rst_n low SHALL immediately force state RUN, ex_valid 0, all ex_* fields 0, halted 0, illegal 0.
REQ-020 reset mid-stall or mid-hazard SHALL discard held contents; first cycle after release, id_ready follows REQ-009.

Structure
REQ-021 Opcode constants, aluOp encodings (000, 010, 011, 100), and FSM state encoding SHALL live in a shared control package also used by ALU control.
REQ-022 Decode SHALL be a combinational sub-module main_ctrl_dec; hazard, FSM and ID/EX register SHALL be in id_ctrl_stage.

Verification
REQ-023 R-type 0x0125 (funCode 0101) offered, no stall -> next cycle ex_valid=1, ex_aluOp=000, ex_funCode=0101, ex_regWrite=1.
REQ-024 LW 0x8300 accepted, then 0x0430 (rs=3) offered -> id_ready=0 one cycle, bubble in EX, 0x0430 accepted next cycle.
REQ-025 SW 0xB210 in EX with ex_stall=1 for 3 cycles -> ex_* stable, id_ready=0, ex_memWrite=1 throughout.
REQ-026 ex_flush=1 with 0x5102 offered -> id_ready=0, next ex_valid=0; ex_flush and ex_stall together -> flush wins.
REQ-027 opcode 0x3000 accepted -> bubble, illegal=1 persisting; then HALT 0xF000 -> halted=1, id_ready=0 until rst_n pulse clears both.
REQ-028 rst_n asserted during hazard bubble -> all outputs 0 asynchronously, before next clock edge.

Source files
------------

// File: rtl/id_ctrl_stage_pkg.sv
// Shared control definitions for the decode stage and ALU control:
// opcode constants, aluOp encodings, decode FSM states and the ID/EX record.
package id_ctrl_stage_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_ALUI  = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b010;
  localparam logic [2:0] ALUOP_IMM    = 3'b011;
  localparam logic [2:0] ALUOP_MEM    = 3'b100;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } id_state_e;

  // One ID/EX register entry; an all-zero entry is a bubble.
  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic [3:0] fun_code;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } id_ex_t;

  function automatic id_ex_t id_ex_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/id_ctrl_stage_main_ctrl_dec.sv
// Main control decoder: purely combinational opcode -> control fields.
// Legal non-HALT instructions come out with valid=1; HALT and undefined
// opcodes come out as a bubble and are flagged separately.
module main_ctrl_dec
  import id_ctrl_stage_pkg::*;
(
  input  logic [15:0] instr_i,
  output id_ex_t      dec_o,
  output logic        is_halt_o,
  output logic        is_illegal_o
);

  // Opcode decode with every output defaulted to a bubble first
  always_comb begin
    dec_o        = id_ex_bubble();
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    dec_o.rd     = instr_i[11:8];
    dec_o.rs     = instr_i[7:4];
    dec_o.rt     = instr_i[3:0];
    unique case (instr_i[15:12])
      OP_RTYPE: begin
        dec_o.valid     = 1'b1;
        dec_o.alu_op    = ALUOP_RTYPE;
        dec_o.fun_code  = instr_i[3:0];
        dec_o.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_o.valid     = 1'b1;
        dec_o.alu_op    = ALUOP_MEM;
        dec_o.mem_read  = 1'b1;
        dec_o.reg_write = 1'b1;
        dec_o.alu_src   = 1'b1;
      end
      OP_SW: begin
        dec_o.valid     = 1'b1;
        dec_o.alu_op    = ALUOP_MEM;
        dec_o.mem_write = 1'b1;
        dec_o.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec_o.valid     = 1'b1;
        dec_o.alu_op    = ALUOP_BRANCH;
        dec_o.branch    = 1'b1;
      end
      OP_ALUI: begin
        dec_o.valid     = 1'b1;
        dec_o.alu_op    = ALUOP_IMM;
        dec_o.reg_write = 1'b1;
        dec_o.alu_src   = 1'b1;
      end
      OP_HALT: begin
        dec_o        = id_ex_bubble();
        is_halt_o    = 1'b1;
      end
      default: begin
        dec_o        = id_ex_bubble();
        is_illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode stage control: load-use hazard detection, RUN/HALTED FSM and the
// ID/EX pipeline register. Priority each edge: flush > stall > hazard >
// accept > idle.
module id_ctrl_stage
  import id_ctrl_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        id_ready,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        ex_valid,
  output logic [2:0]  ex_aluOp,
  output logic [3:0]  ex_funCode,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_branch,
  output logic        ex_aluSrc,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic        halted,
  output logic        illegal
);

  id_state_e state_q, state_d;
  id_ex_t    id_ex_q, id_ex_d;
  logic      illegal_q, illegal_d;
  id_ex_t    dec;
  logic      dec_halt, dec_illegal;
  logic      hazard, accept;

  main_ctrl_dec u_dec (
    .instr_i      (if_instr),
    .dec_o        (dec),
    .is_halt_o    (dec_halt),
    .is_illegal_o (dec_illegal)
  );

  // Load-use hazard against the load currently sitting in EX; r0 never conflicts
  always_comb begin
    hazard = if_valid & id_ex_q.valid & id_ex_q.mem_read & (id_ex_q.rd != 4'd0) &
             ((id_ex_q.rd == if_instr[7:4]) | (id_ex_q.rd == if_instr[3:0]));
    id_ready = (state_q == ST_RUN) & ~ex_stall & ~ex_flush & ~hazard;
    accept   = id_ready & if_valid;
  end

  // Next-state for FSM, ID/EX register and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    id_ex_d   = id_ex_bubble();
    illegal_d = illegal_q | (accept & dec_illegal);
    if (ex_flush) begin
      id_ex_d = id_ex_bubble();
    end else if (ex_stall) begin
      id_ex_d = id_ex_q;
    end else if (accept) begin
      // HALT and illegal opcodes decode to a bubble with valid=0
      id_ex_d = dec;
      if (dec_halt) state_d = ST_HALTED;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      id_ex_q   <= id_ex_bubble();
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_ex_q   <= id_ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid    = id_ex_q.valid;
  assign ex_aluOp    = id_ex_q.alu_op;
  assign ex_funCode  = id_ex_q.fun_code;
  assign ex_regWrite = id_ex_q.reg_write;
  assign ex_memRead  = id_ex_q.mem_read;
  assign ex_memWrite = id_ex_q.mem_write;
  assign ex_branch   = id_ex_q.branch;
  assign ex_aluSrc   = id_ex_q.alu_src;
  assign ex_rd       = id_ex_q.rd;
  assign ex_rs       = id_ex_q.rs;
  assign ex_rt       = id_ex_q.rt;
  assign halted      = (state_q == ST_HALTED);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode, hazard bubble, stall, flush,
// illegal/HALT handling and asynchronous reset.
module tb_id_ctrl_stage;

  logic        clk, rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        id_ready;
  logic        ex_stall, ex_flush;
  logic        ex_valid;
  logic [2:0]  ex_aluOp;
  logic [3:0]  ex_funCode;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_aluSrc;
  logic [3:0]  ex_rd, ex_rs, ex_rt;
  logic        halted, illegal;

  int n_cmp = 0;
  int n_err = 0;

  id_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_aluOp(ex_aluOp), .ex_funCode(ex_funCode),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_branch(ex_branch), .ex_aluSrc(ex_aluSrc),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 16'h0000; ex_stall = 1'b0; ex_flush = 1'b0;
    #3;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_aluop",    32'(ex_aluOp), 0);
    chk("rst_halted",   32'(halted), 0);
    chk("rst_illegal",  32'(illegal), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // R-type 0x0125
    if_valid = 1'b1; if_instr = 16'h0125; #1;
    chk("r_ready", 32'(id_ready), 1);
    tick();
    chk("r_valid",  32'(ex_valid), 1);
    chk("r_aluop",  32'(ex_aluOp), 0);
    chk("r_fun",    32'(ex_funCode), 5);
    chk("r_regw",   32'(ex_regWrite), 1);
    chk("r_memrd",  32'(ex_memRead), 0);
    chk("r_rd",     32'(ex_rd), 1);
    chk("r_rs",     32'(ex_rs), 2);
    chk("r_rt",     32'(ex_rt), 5);

    // LW 0x8300 then dependent 0x0430 (rs=3)
    if_instr = 16'h8300; #1;
    tick();
    chk("lw_memrd", 32'(ex_memRead), 1);
    chk("lw_alusrc", 32'(ex_aluSrc), 1);
    chk("lw_aluop", 32'(ex_aluOp), 4);
    chk("lw_fun",   32'(ex_funCode), 0);
    chk("lw_rd",    32'(ex_rd), 3);
    if_instr = 16'h0430; #1;
    chk("hz_ready0", 32'(id_ready), 0);
    tick();
    chk("hz_bubble",   32'(ex_valid), 0);
    chk("hz_bub_mrd",  32'(ex_memRead), 0);
    chk("hz_ready1",   32'(id_ready), 1);
    tick();
    chk("hz_acc_valid", 32'(ex_valid), 1);
    chk("hz_acc_rd",    32'(ex_rd), 4);
    chk("hz_acc_rs",    32'(ex_rs), 3);

    // SW 0xB210 held by a 3-cycle stall
    if_instr = 16'hB210; #1;
    tick();
    chk("sw_memw",  32'(ex_memWrite), 1);
    chk("sw_regw",  32'(ex_regWrite), 0);
    chk("sw_aluop", 32'(ex_aluOp), 4);
    if_instr = 16'h0125; ex_stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_ready", 32'(id_ready), 0);
      tick();
      chk("st_valid", 32'(ex_valid), 1);
      chk("st_memw",  32'(ex_memWrite), 1);
      chk("st_rd",    32'(ex_rd), 2);
      chk("st_rs",    32'(ex_rs), 1);
    end
    ex_stall = 1'b0;

    // Flush with 0x5102 offered
    if_instr = 16'h5102; ex_flush = 1'b1; #1;
    chk("fl_ready", 32'(id_ready), 0);
    tick();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_memw",  32'(ex_memWrite), 0);
    ex_flush = 1'b0; #1;
    tick();
    chk("ai_valid",  32'(ex_valid), 1);
    chk("ai_aluop",  32'(ex_aluOp), 3);
    chk("ai_alusrc", 32'(ex_aluSrc), 1);
    chk("ai_fun",    32'(ex_funCode), 0);
    // Flush and stall together: flush wins
    if_valid = 1'b0; ex_flush = 1'b1; ex_stall = 1'b1; #1;
    tick();
    chk("fs_valid", 32'(ex_valid), 0);
    chk("fs_regw",  32'(ex_regWrite), 0);
    ex_flush = 1'b0; ex_stall = 1'b0;

    // BEQ 0x4123: funCode forced to zero
    if_valid = 1'b1; if_instr = 16'h4123; #1;
    tick();
    chk("beq_branch", 32'(ex_branch), 1);
    chk("beq_aluop",  32'(ex_aluOp), 2);
    chk("beq_fun",    32'(ex_funCode), 0);
    // Idle
    if_valid = 1'b0; #1;
    tick();
    chk("idle_valid", 32'(ex_valid), 0);

    // LW to r0 never raises a hazard
    if_valid = 1'b1; if_instr = 16'h8000; #1;
    tick();
    if_instr = 16'h0100; #1;
    chk("r0_ready", 32'(id_ready), 1);
    tick();

    // Illegal opcode 0x3000
    if_instr = 16'h3000; #1;
    chk("il_ready", 32'(id_ready), 1);
    tick();
    chk("il_valid", 32'(ex_valid), 0);
    chk("il_flag",  32'(illegal), 1);
    if_instr = 16'h0125; #1;
    tick();
    chk("il_next_valid", 32'(ex_valid), 1);
    chk("il_sticky",     32'(illegal), 1);

    // HALT with coincident flush is not taken
    if_instr = 16'hF000; ex_flush = 1'b1; #1;
    tick();
    chk("hf_halted", 32'(halted), 0);
    ex_flush = 1'b0; #1;
    tick();
    chk("h_halted", 32'(halted), 1);
    chk("h_valid",  32'(ex_valid), 0);
    if_instr = 16'h0125; #1;
    chk("h_ready", 32'(id_ready), 0);
    tick();
    chk("h_hold_valid",  32'(ex_valid), 0);
    chk("h_hold_halted", 32'(halted), 1);
    chk("h_hold_ill",    32'(illegal), 1);

    // Reset pulse between edges clears halted/illegal at once
    rst_n = 1'b0; #1;
    chk("rp_halted",  32'(halted), 0);
    chk("rp_illegal", 32'(illegal), 0);
    rst_n = 1'b1; #1;
    chk("rp_ready", 32'(id_ready), 1);
    tick();
    chk("rp_valid", 32'(ex_valid), 1);

    // Reset while a load-use hazard is pending (LW 0x8500, then rt=5 user)
    if_instr = 16'h8500; #1;
    tick();
    if_instr = 16'h0105; #1;
    chk("rh_ready0", 32'(id_ready), 0);
    rst_n = 1'b0; #1;
    chk("rh_valid",  32'(ex_valid), 0);
    chk("rh_memrd",  32'(ex_memRead), 0);
    chk("rh_rd",     32'(ex_rd), 0);
    chk("rh_ready",  32'(id_ready), 1);
    rst_n = 1'b1; #1;
    tick();
    chk("rh_acc_valid", 32'(ex_valid), 1);
    chk("rh_acc_rt",    32'(ex_rt), 5);
    chk("rh_acc_fun",   32'(ex_funCode), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
